// File: rtl/i2s_pkg.sv
// Shared types for the I2S sample scheduler: stereo frame layout, FSM encoding, level width.
package i2s_pkg;

  localparam int SAMPLE_W = 24;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } frame_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_PRIME = PRIME;
  localparam logic [1:0] ST_RUN   = RUN;

  // Level counter must represent 0..DEPTH inclusive.
  function automatic int levelWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/i2s_frame_fifo.sv
// Synchronous stereo-frame FIFO, registered level, head visible combinationally.
// Push when full and pop when empty are ignored; flush empties it in one cycle.
module i2s_frame_fifo
  import i2s_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst,
  input  logic                         i_Flush,
  input  logic                         i_Push,
  input  frame_t                       i_PushData,
  input  logic                         i_Pop,
  output frame_t                       o_Head,
  output logic [levelWidth(DEPTH)-1:0] o_Level,
  output logic                         o_Full,
  output logic                         o_Empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = levelWidth(DEPTH);

  frame_t        mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          doPush;
  logic          doPop;

  assign o_Full  = (o_Level == LW'(DEPTH));
  assign o_Empty = (o_Level == '0);
  assign doPush  = i_Push && !o_Full;
  assign doPop   = i_Pop && !o_Empty;
  assign o_Head  = mem[rdPtr];

  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Flush) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      o_Level <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   o_Level <= o_Level + LW'(1);
        2'b01:   o_Level <= o_Level - LW'(1);
        default: o_Level <= o_Level;
      endcase
    end
  end

  // Storage needs no reset: pointers and level define which entries are live.
  always_ff @(posedge i_Clk) begin
    if (doPush) mem[wrPtr] <= i_PushData;
  end

endmodule

// File: rtl/i2s_stream_ctrl.sv
// Round-robin CPU/DMA frame scheduler feeding the I2S driver; pop-to-data latency 1 cycle (2 with
// I2S_STREAM_CTRL_VOLUME_EN). Producers see ready only when not IDLE and the FIFO is not full.
module i2s_stream_ctrl
  import i2s_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int PRIME_LEVEL = 2,
  parameter int LOW_WATER   = 2
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst,
  input  logic                         i_Enable,
`ifdef I2S_STREAM_CTRL_VOLUME_EN
  input  logic [8:0]                   i_Volume,
`endif
  input  logic                         i_CpuValid,
  input  logic [SAMPLE_W-1:0]          i_CpuLeft,
  input  logic [SAMPLE_W-1:0]          i_CpuRight,
  output logic                         o_CpuReady,
  input  logic                         i_DmaValid,
  input  logic [SAMPLE_W-1:0]          i_DmaLeft,
  input  logic [SAMPLE_W-1:0]          i_DmaRight,
  output logic                         o_DmaReady,
  input  logic                         i_ReqNextData,
  output logic [SAMPLE_W-1:0]          o_LeftData,
  output logic [SAMPLE_W-1:0]          o_RightData,
  output logic [levelWidth(DEPTH)-1:0] o_Level,
  output logic                         o_LowWater,
  output logic                         o_Underrun,
  input  logic                         i_ClearUnderrun
);

  localparam int             LW        = levelWidth(DEPTH);
  localparam logic [LW-1:0]  PRIME_LVL = LW'(PRIME_LEVEL);
  localparam logic [LW-1:0]  LOW_LVL   = LW'(LOW_WATER);

  logic [1:0] state;
  logic       reqD;
  logic       popEvent;
  logic       flush;
  logic       grantDma;
  logic       canWrite;
  logic       cpuSel;
  logic       cpuAccept;
  logic       dmaAccept;
  logic       fifoPush;
  logic       fifoPop;
  logic       fifoFull;
  logic       fifoEmpty;
  logic       loadEn;
  logic       underrunSet;
  frame_t     pushFrame;
  frame_t     fifoHead;
  frame_t     loadFrame;

  assign popEvent = i_ReqNextData && !reqD;
  assign flush    = !i_Enable || (state == ST_IDLE);

  // Lone requester wins outright; on contention the pointer decides.
  assign canWrite   = (state != ST_IDLE) && !fifoFull;
  assign cpuSel     = (i_CpuValid && !i_DmaValid) || ((i_CpuValid == i_DmaValid) && !grantDma);
  assign o_CpuReady = canWrite && cpuSel;
  assign o_DmaReady = canWrite && !cpuSel;
  assign cpuAccept  = i_CpuValid && o_CpuReady;
  assign dmaAccept  = i_DmaValid && o_DmaReady;
  assign fifoPush   = cpuAccept || dmaAccept;
  assign pushFrame  = cpuAccept ? {i_CpuLeft, i_CpuRight} : {i_DmaLeft, i_DmaRight};

  assign loadEn      = popEvent && (state != ST_IDLE);
  assign fifoPop     = popEvent && (state == ST_RUN) && !fifoEmpty;
  assign underrunSet = popEvent && (state == ST_RUN) && fifoEmpty && i_Enable;
  assign loadFrame   = fifoPop ? fifoHead : '0;
  assign o_LowWater  = (o_Level <= LOW_LVL);

  i2s_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Flush    (flush),
    .i_Push     (fifoPush),
    .i_PushData (pushFrame),
    .i_Pop      (fifoPop),
    .o_Head     (fifoHead),
    .o_Level    (o_Level),
    .o_Full     (fifoFull),
    .o_Empty    (fifoEmpty)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) reqD <= 1'b0;
    else       reqD <= i_ReqNextData;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst || !i_Enable) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state <= ST_PRIME;
        ST_PRIME: if (o_Level >= PRIME_LVL) state <= ST_RUN;
        ST_RUN:   if (popEvent && fifoEmpty) state <= ST_PRIME;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst || flush) grantDma <= 1'b0;
    else if (cpuAccept) grantDma <= 1'b1;
    else if (dmaAccept) grantDma <= 1'b0;
  end

  // Set wins over a same-cycle clear.
  always_ff @(posedge i_Clk) begin
    if (i_Rst)                o_Underrun <= 1'b0;
    else if (underrunSet)     o_Underrun <= 1'b1;
    else if (i_ClearUnderrun) o_Underrun <= 1'b0;
  end

`ifdef I2S_STREAM_CTRL_VOLUME_EN
  function automatic logic [SAMPLE_W-1:0] scaleSample(input logic [SAMPLE_W-1:0] s,
                                                      input logic [8:0] vol);
    logic [8:0]                 v;
    logic signed [SAMPLE_W+9:0] prod;
    v    = (vol > 9'd256) ? 9'd256 : vol;
    prod = $signed(s) * $signed({1'b0, v});
    return SAMPLE_W'(prod >>> 8);
  endfunction

  frame_t stageFrame;
  logic   stageVld;

  always_ff @(posedge i_Clk) begin
    if (i_Rst || flush) begin
      stageFrame  <= '0;
      stageVld    <= 1'b0;
      o_LeftData  <= '0;
      o_RightData <= '0;
    end else begin
      stageVld <= loadEn;
      if (loadEn) stageFrame <= loadFrame;
      if (stageVld) begin
        o_LeftData  <= scaleSample(stageFrame.left, i_Volume);
        o_RightData <= scaleSample(stageFrame.right, i_Volume);
      end
    end
  end
`else
  always_ff @(posedge i_Clk) begin
    if (i_Rst || flush) begin
      o_LeftData  <= '0;
      o_RightData <= '0;
    end else if (loadEn) begin
      o_LeftData  <= loadFrame.left;
      o_RightData <= loadFrame.right;
    end
  end
`endif

endmodule

// File: doc/i2s_stream_ctrl.md
Name: i2s_stream_ctrl

Overview:
Sample scheduler in front of the I2S output driver. Arbitrates stereo 24-bit samples from two producers, the CPU bus port and the DMA stream port, into a small FIFO. Presents the head sample to the driver whenever the driver requests the next sample. Tracks fill level, priming, low-water and underrun status for the I2S peripheral register block.

Parameters:
DEPTH, 8, FIFO depth in stereo frames; power of 2, minimum 4
PRIME_LEVEL, 2, frames required before playback starts or resumes
LOW_WATER, 2, o_LowWater asserts when level <= this value

Ports:
i_Clk  in  1  system clock; single clock domain
i_Rst  in  1  synchronous, active-high reset
i_Enable  in  1  playback enable
i_CpuValid  in  1  CPU frame valid
i_CpuLeft  in  24  CPU left sample
i_CpuRight  in  24  CPU right sample
o_CpuReady  out  1  CPU frame accepted when valid&&ready
i_DmaValid  in  1  DMA frame valid
i_DmaLeft  in  24  DMA left sample
i_DmaRight  in  24  DMA right sample
o_DmaReady  out  1  DMA frame accepted when valid&&ready
i_ReqNextData  in  1  driver request, already synchronised to i_Clk; level, multi-cycle high
o_LeftData  out  24  left sample to driver
o_RightData  out  24  right sample to driver
o_Level  out  clog2(DEPTH)+1  FIFO occupancy
o_LowWater  out  1  level <= LOW_WATER (combinational from level)
o_Underrun  out  1  sticky underrun flag
i_ClearUnderrun  in  1  one-cycle clear of o_Underrun

Behaviour:
- Reset: FIFO empty, o_Level=0, o_LeftData=o_RightData=0, o_Underrun=0, both readys 0, request edge register=0, state IDLE.
- Request detection: pop event = i_ReqNextData && !req_d, where req_d is i_ReqNextData registered. Only one pop occurs per high pulse.
- Arbitration: at most one write per cycle. A port's ready is high only when state != IDLE, the FIFO is not full, and the round-robin grant selects that port.
  - Grant pointer alternates after each accepted write.
  - With a single valid requester, that requester gets the grant the same cycle.
  - Ready depends on current full only; there is no pop-to-push bypass.
- Pop timing: a pop event in cycle N loads the head into o_LeftData/o_RightData at N+1. Level updates at N+1; a simultaneous push and pop leaves the level unchanged.
- FSM:
  - IDLE: FIFO flushed and held empty; outputs 0; pops ignored. Moves to PRIME when i_Enable=1.
  - PRIME: writes accepted; pop events load 0 and do not set underrun. Moves to RUN when level >= PRIME_LEVEL.
  - RUN: a pop event with a non-empty FIFO loads the head frame. A pop event with an empty FIFO loads 0, sets o_Underrun and returns to PRIME. A same-cycle push into an empty FIFO does not rescue that pop.
  - Any state: i_Enable=0 moves to IDLE next cycle, flushes the FIFO and zeroes the outputs. Any frame in flight is dropped.
- o_Underrun: a set and i_ClearUnderrun in the same cycle resolves to set.
- Pointers wrap modulo DEPTH. Full means level==DEPTH.
- i_Rst mid-operation behaves exactly like reset; no partial frame survives.

Optional Feature:
I2S_STREAM_CTRL_VOLUME_EN
- Enabled: adds port i_Volume [8:0] (256 = unity; values >256 clamp to 256).
  - Each loaded sample = (signed sample * volume) >>> 8.
  - Result is registered, so data latency is N+2. The zero and underrun paths also take N+2.
- Disabled: no i_Volume port; latency N+1; data passes bit-exact.

Decomposition:
- Package i2s_pkg: SAMPLE_W=24, stereo frame struct/typedef {left,right}, FSM state enum (IDLE, PRIME, RUN), and the level-width helper function.
- One sub-module: i2s_frame_fifo (synchronous FIFO of 48-bit frames with level output). Arbiter, FSM and output stage stay in the top level.

Test Plan:
- Reset, then i_Enable=1 with no writes, then pulse i_ReqNextData 3 times -> outputs stay 0, o_Underrun=0, state remains PRIME.
- CPU writes L=0x123456/R=0xABCDEF and 0x000001/0x000002, then a request pulse held 4 cycles -> exactly one pop; outputs 0x123456/0xABCDEF one cycle after the rising edge; o_Level 2->1.
- CPU and DMA valid continuously from empty, DEPTH=8 -> grants alternate CPU,DMA,...; after 8 writes both readys are 0; o_Level=8; o_LowWater=0.
- RUN with level 1, then two request edges -> first pops the frame; second outputs 0, sets o_Underrun and returns to PRIME. i_ClearUnderrun pulse -> o_Underrun=0.
- Level 4 in RUN, then i_Enable=0 for one cycle, then re-enable -> o_Level=0 and outputs 0 the next cycle; returns to PRIME.
- With VOLUME_EN and i_Volume=128, sample 0x7FFFFE -> output 0x3FFFFF at N+2. Sample 0x800000 -> output 0xC00000.
